// File: rtl/jtkcpu_intarb_if.sv
// Signal bundle between the CPU pins / microcode sequencer and the interrupt arbiter.
// The arbiter connects through the slave modport; pins and microcode drive the master side.
interface jtkcpu_intarb_if;
  logic       cen;
  logic       nmi_n;
  logic       firq_n;
  logic       irq_n;
  logic [7:0] cc;
  logic       nmi_arm;
  logic       ni;
  logic       halt;
  logic       cwai;
  logic       sync;
  logic       vec_done;
  logic       int_go;
  logic [3:0] intvec;
  logic       psh_all;
  logic       skip_psh;
  logic       set_i;
  logic       set_f;
  logic       sync_exit;
  logic       busy;

  modport master (
    output cen, nmi_n, firq_n, irq_n, cc, nmi_arm, ni, halt, cwai, sync, vec_done,
    input  int_go, intvec, psh_all, skip_psh, set_i, set_f, sync_exit, busy
  );

  modport slave (
    input  cen, nmi_n, firq_n, irq_n, cc, nmi_arm, ni, halt, cwai, sync, vec_done,
    output int_go, intvec, psh_all, skip_psh, set_i, set_f, sync_exit, busy
  );
endinterface

// File: rtl/jtkcpu_intarb.sv
// KONAMI CPU interrupt arbiter: pin conditioning, NMI arming, priority resolution
// and sequencing of reset / NMI / FIRQ / IRQ service including CWAI and SYNC waits.
module jtkcpu_intarb (
  input  logic           clk,
  input  logic           rst_n,
  jtkcpu_intarb_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SRV   = 3'd2,
    ST_CWAIT = 3'd3,
    ST_SYNCW = 3'd4
  } state_t;

  localparam logic [3:0] VEC_RST  = 4'hE;
  localparam logic [3:0] VEC_NMI  = 4'hC;
  localparam logic [3:0] VEC_IRQ  = 4'h8;
  localparam logic [3:0] VEC_FIRQ = 4'h6;

  state_t     state_q, state_d;
  logic [1:0] nmi_sy_q, firq_sy_q, irq_sy_q;
  logic       nmi_prev_q, nmi_pend_q, nmi_pend_d, nmi_armed_q;
  logic       int_go_q, int_go_d;
  logic [3:0] intvec_q, intvec_d;
  logic       psh_all_q, psh_all_d;
  logic       skip_psh_q, skip_psh_d;
  logic       set_i_q, set_i_d;
  logic       set_f_q, set_f_d;
  logic       sync_exit_q, sync_exit_d;
  logic       busy_q, busy_d;

  logic       nmi_fall_s, firq_req_s, irq_req_s, any_req_s, wake_s;
  logic       win_full_s, win_setf_s, nmi_sel_s;
  logic [3:0] win_vec_s;
  logic       unused_cc_s;

  assign unused_cc_s = ^{bus.cc[7], bus.cc[5], bus.cc[3:0]};

  assign nmi_fall_s = nmi_prev_q & ~nmi_sy_q[1];
  assign firq_req_s = ~firq_sy_q[1] & ~bus.cc[6];
  assign irq_req_s  = ~irq_sy_q[1] & ~bus.cc[4];
  assign any_req_s  = nmi_pend_q | firq_req_s | irq_req_s;
  // SYNC wakes on any low line regardless of masks
  assign wake_s     = ~nmi_sy_q[1] | ~firq_sy_q[1] | ~irq_sy_q[1] | nmi_pend_q;
  assign win_vec_s  = nmi_pend_q ? VEC_NMI : (firq_req_s ? VEC_FIRQ : VEC_IRQ);
  assign win_full_s = nmi_pend_q | ~firq_req_s;
  assign win_setf_s = nmi_pend_q | firq_req_s;

  // Pin synchronisers, NMI edge history and arming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_sy_q    <= 2'b11;
      firq_sy_q   <= 2'b11;
      irq_sy_q    <= 2'b11;
      nmi_prev_q  <= 1'b1;
      nmi_pend_q  <= 1'b0;
      nmi_armed_q <= 1'b0;
    end else if (bus.cen) begin
      nmi_sy_q    <= {nmi_sy_q[0], bus.nmi_n};
      firq_sy_q   <= {firq_sy_q[0], bus.firq_n};
      irq_sy_q    <= {irq_sy_q[0], bus.irq_n};
      nmi_prev_q  <= nmi_sy_q[1];
      nmi_pend_q  <= nmi_pend_d;
      nmi_armed_q <= nmi_armed_q | bus.nmi_arm;
    end
  end

  // A fresh armed edge outranks the clear caused by selecting NMI
  always_comb begin
    nmi_pend_d = nmi_pend_q;
    if (nmi_fall_s && nmi_armed_q) begin
      nmi_pend_d = 1'b1;
    end else if (nmi_sel_s) begin
      nmi_pend_d = 1'b0;
    end else begin
      nmi_pend_d = nmi_pend_q;
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      int_go_q    <= 1'b0;
      intvec_q    <= VEC_RST;
      psh_all_q   <= 1'b0;
      skip_psh_q  <= 1'b1;
      set_i_q     <= 1'b0;
      set_f_q     <= 1'b0;
      sync_exit_q <= 1'b0;
      busy_q      <= 1'b1;
    end else if (bus.cen) begin
      state_q     <= state_d;
      int_go_q    <= int_go_d;
      intvec_q    <= intvec_d;
      psh_all_q   <= psh_all_d;
      skip_psh_q  <= skip_psh_d;
      set_i_q     <= set_i_d;
      set_f_q     <= set_f_d;
      sync_exit_q <= sync_exit_d;
      busy_q      <= busy_d;
    end
  end

  // Next state and service-start decisions
  always_comb begin
    state_d     = state_q;
    int_go_d    = 1'b0;
    intvec_d    = intvec_q;
    psh_all_d   = psh_all_q;
    skip_psh_d  = skip_psh_q;
    set_i_d     = 1'b0;
    set_f_d     = 1'b0;
    sync_exit_d = 1'b0;
    nmi_sel_s   = 1'b0;
    case (state_q)
      ST_RST: begin
        int_go_d   = 1'b1;
        intvec_d   = VEC_RST;
        psh_all_d  = 1'b0;
        skip_psh_d = 1'b1;
        set_i_d    = 1'b1;
        set_f_d    = 1'b1;
        state_d    = ST_SRV;
      end
      ST_IDLE: begin
        if (bus.ni && !bus.halt && any_req_s) begin
          int_go_d   = 1'b1;
          intvec_d   = win_vec_s;
          psh_all_d  = win_full_s;
          skip_psh_d = 1'b0;
          set_i_d    = 1'b1;
          set_f_d    = win_setf_s;
          nmi_sel_s  = nmi_pend_q;
          state_d    = ST_SRV;
        end else if (bus.cwai) begin
          psh_all_d = 1'b1;
          state_d   = ST_CWAIT;
        end else if (bus.sync) begin
          state_d = ST_SYNCW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SRV: begin
        if (bus.vec_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SRV;
        end
      end
      ST_CWAIT: begin
        // Frame is already stacked in full, so psh_all stays at its CWAI value
        if (any_req_s) begin
          int_go_d   = 1'b1;
          intvec_d   = win_vec_s;
          skip_psh_d = 1'b1;
          set_i_d    = 1'b1;
          set_f_d    = win_setf_s;
          nmi_sel_s  = nmi_pend_q;
          state_d    = ST_SRV;
        end else begin
          state_d = ST_CWAIT;
        end
      end
      ST_SYNCW: begin
        if (any_req_s) begin
          int_go_d   = 1'b1;
          intvec_d   = win_vec_s;
          psh_all_d  = win_full_s;
          skip_psh_d = 1'b0;
          set_i_d    = 1'b1;
          set_f_d    = win_setf_s;
          nmi_sel_s  = nmi_pend_q;
          state_d    = ST_SRV;
        end else if (wake_s) begin
          sync_exit_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_SYNCW;
        end
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.int_go    = int_go_q;
  assign bus.intvec    = intvec_q;
  assign bus.psh_all   = psh_all_q;
  assign bus.skip_psh  = skip_psh_q;
  assign bus.set_i     = set_i_q;
  assign bus.set_f     = set_f_q;
  assign bus.sync_exit = sync_exit_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_jtkcpu_intarb.sv
// Bench for jtkcpu_intarb: directed vector table, hand-written NMI/reset sequences,
// and random stimulus compared against a mode-level reference model.
module tb_jtkcpu_intarb;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  jtkcpu_intarb_if bus ();

  jtkcpu_intarb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       firq_n;
    logic       irq_n;
    logic [7:0] cc;
    logic       ni;
    logic       halt;
    logic       vec_done;
    logic       cwai;
    logic       sync;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl [20];

  // expected-output packing: go, vec, psh_all, skip_psh, set_i, set_f, sync_exit, busy
  function automatic logic [10:0] mk(input logic go, input logic [3:0] v, input logic psh,
                                     input logic skip, input logic si, input logic sf,
                                     input logic sx, input logic bsy);
    return {go, v, psh, skip, si, sf, sx, bsy};
  endfunction

  function automatic vec_t row(input logic f, input logic i, input logic [7:0] c, input logic n,
                               input logic h, input logic vd, input logic cw, input logic sy,
                               input logic [10:0] e);
    vec_t r;
    r.firq_n = f; r.irq_n = i; r.cc = c; r.ni = n; r.halt = h;
    r.vec_done = vd; r.cwai = cw; r.sync = sy; r.exp = e;
    return r;
  endfunction

  function automatic logic [10:0] dut_out();
    return {bus.int_go, bus.intvec, bus.psh_all, bus.skip_psh, bus.set_i, bus.set_f,
            bus.sync_exit, bus.busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.cen = 1'b1; bus.nmi_n = 1'b1; bus.firq_n = 1'b1; bus.irq_n = 1'b1;
    bus.cc = 8'h50; bus.nmi_arm = 1'b0; bus.ni = 1'b0; bus.halt = 1'b0;
    bus.cwai = 1'b0; bus.sync = 1'b0; bus.vec_done = 1'b0;
  endtask

  // ---------------- reference model ----------------
  string      m_mode;
  bit         m_armed, m_pend;
  bit         nh [3];
  bit         fh [2];
  bit         ih [2];
  logic       e_go, e_psh, e_skip, e_si, e_sf, e_sx, e_busy;
  logic [3:0] e_vec;

  task automatic model_reset();
    m_mode = "RST"; m_armed = 1'b0; m_pend = 1'b0;
    for (int k = 0; k < 3; k++) nh[k] = 1'b1;
    for (int k = 0; k < 2; k++) begin fh[k] = 1'b1; ih[k] = 1'b1; end
    e_go = 1'b0; e_vec = 4'hE; e_psh = 1'b0; e_skip = 1'b1;
    e_si = 1'b0; e_sf = 1'b0; e_sx = 1'b0; e_busy = 1'b1;
  endtask

  task automatic serve(input logic [3:0] v, input logic full, input logic skip, input logic sf);
    e_go = 1'b1; e_vec = v; e_psh = full; e_skip = skip; e_si = 1'b1; e_sf = sf;
    m_mode = "SRV";
  endtask

  // One enabled clock: pins seen two enables late, NMI edge one more enable late
  task automatic model_edge();
    bit fall, freq, ireq, anyreq, wake, sel_nmi;
    logic [3:0] wv;
    if (!bus.cen) return;
    fall   = nh[2] && !nh[1];
    freq   = !fh[1] && !bus.cc[6];
    ireq   = !ih[1] && !bus.cc[4];
    anyreq = m_pend || freq || ireq;
    wake   = !nh[1] || !fh[1] || !ih[1] || m_pend;
    wv     = m_pend ? 4'hC : (freq ? 4'h6 : 4'h8);
    sel_nmi = 1'b0;
    e_go = 1'b0; e_si = 1'b0; e_sf = 1'b0; e_sx = 1'b0;
    if (m_mode == "RST") begin
      serve(4'hE, 1'b0, 1'b1, 1'b1);
    end else if (m_mode == "IDLE") begin
      if (bus.ni && !bus.halt && anyreq) begin
        serve(wv, wv != 4'h6, 1'b0, wv != 4'h8); sel_nmi = m_pend;
      end else if (bus.cwai) begin
        m_mode = "CWAIT"; e_psh = 1'b1;
      end else if (bus.sync) begin
        m_mode = "SYNCW";
      end
    end else if (m_mode == "SRV") begin
      if (bus.vec_done) m_mode = "IDLE";
    end else if (m_mode == "CWAIT") begin
      if (anyreq) begin serve(wv, 1'b1, 1'b1, wv != 4'h8); sel_nmi = m_pend; end
    end else begin
      if (anyreq) begin
        serve(wv, wv != 4'h6, 1'b0, wv != 4'h8); sel_nmi = m_pend;
      end else if (wake) begin
        e_sx = 1'b1; m_mode = "IDLE";
      end
    end
    e_busy = (m_mode != "IDLE");
    if (fall && m_armed) m_pend = 1'b1;
    else if (sel_nmi) m_pend = 1'b0;
    if (bus.nmi_arm) m_armed = 1'b1;
    nh[2] = nh[1]; nh[1] = nh[0]; nh[0] = bus.nmi_n;
    fh[1] = fh[0]; fh[0] = bus.firq_n;
    ih[1] = ih[0]; ih[0] = bus.irq_n;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    idle_inputs();
    bus.cc = 8'h00;

    tbl[0]  = row(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 4'hE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl[1]  = row(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl[2]  = row(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[3]  = row(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[4]  = row(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[5]  = row(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl[6]  = row(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl[7]  = row(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[8]  = row(1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl[9]  = row(1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[10] = row(1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl[11] = row(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[12] = row(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[13] = row(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl[14] = row(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl[15] = row(1'b0, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl[16] = row(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[17] = row(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl[18] = row(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl[19] = row(1'b1, 1'b1, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    step(); step();
    chk("reset_values", {21'd0, dut_out()}, {21'd0, mk(1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)});
    rst_n = 1'b1;

    for (int r = 0; r < 20; r++) begin
      bus.firq_n = tbl[r].firq_n; bus.irq_n = tbl[r].irq_n; bus.cc = tbl[r].cc;
      bus.ni = tbl[r].ni; bus.halt = tbl[r].halt; bus.vec_done = tbl[r].vec_done;
      bus.cwai = tbl[r].cwai; bus.sync = tbl[r].sync;
      step();
      chk($sformatf("table_row%0d", r), {21'd0, dut_out()}, {21'd0, tbl[r].exp});
    end

    // NMI edge before arming is forgotten
    idle_inputs();
    repeat (3) step();
    bus.nmi_n = 1'b0; repeat (3) step();
    bus.nmi_n = 1'b1; repeat (3) step();
    bus.nmi_arm = 1'b1; step(); bus.nmi_arm = 1'b0;
    bus.ni = 1'b1; seen = 1'b0;
    for (int k = 0; k < 6; k++) begin step(); seen = seen | bus.int_go; end
    chk("nmi_unarmed_ignored", {31'd0, seen}, 32'd0);

    // armed edge: pend after three enables, int_go visible after the fourth
    bus.nmi_n = 1'b0;
    step(); step(); step();
    chk("nmi_not_early", {31'd0, bus.int_go}, 32'd0);
    step();
    chk("nmi_service", {21'd0, dut_out()}, {21'd0, mk(1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1)});
    bus.ni = 1'b0; bus.nmi_n = 1'b1; bus.vec_done = 1'b1; step(); bus.vec_done = 1'b0;
    chk("nmi_back_idle", {31'd0, bus.busy}, 32'd0);
    bus.ni = 1'b1; seen = 1'b0;
    for (int k = 0; k < 4; k++) begin step(); seen = seen | bus.int_go; end
    chk("nmi_pend_cleared", {31'd0, seen}, 32'd0);

    // IRQ in service, then asynchronous reset
    bus.cc = 8'h00; bus.irq_n = 1'b0; seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin step(); seen = bus.int_go; end
    chk("irq_go_seen", {31'd0, seen}, 32'd1);
    chk("irq_vector", {28'd0, bus.intvec}, 32'h8);
    bus.ni = 1'b0; step();
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {21'd0, dut_out()}, {21'd0, mk(1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)});
    step(); idle_inputs(); rst_n = 1'b1; step();
    chk("reset_vector_again", {21'd0, dut_out()}, {21'd0, mk(1'b1, 4'hE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1)});

    // randomized run against the reference model
    rst_n = 1'b0; idle_inputs(); model_reset(); step();
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom % 400) != 0;
      bus.cen = ($urandom % 8) != 0;
      if (($urandom % 10) == 0) bus.nmi_n = ~bus.nmi_n;
      if (($urandom % 12) == 0) bus.firq_n = ~bus.firq_n;
      if (($urandom % 8) == 0) bus.irq_n = ~bus.irq_n;
      if (($urandom % 6) == 0) bus.cc = {1'b0, 1'($urandom), 1'b0, 1'($urandom), 4'h0};
      bus.nmi_arm  = ($urandom % 40) == 0;
      bus.ni       = ($urandom % 3) == 0;
      bus.halt     = ($urandom % 8) == 0;
      bus.cwai     = ($urandom % 20) == 0;
      bus.sync     = ($urandom % 25) == 0;
      bus.vec_done = (m_mode == "SRV") ? (($urandom % 4) == 0) : (($urandom % 30) == 0);
      #1;
      if (!rst_n) model_reset();
      else model_edge();
      step();
      chk("random", {21'd0, dut_out()},
          {21'd0, mk(e_go, e_vec, e_psh, e_skip, e_si, e_sf, e_sx, e_busy)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
